// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, state type and stall-merge helper for the pipeline sequencer.
// Stall masks are contiguous from bit 0 (PC) up to the requesting stage.
package pipeline_ctrl_pkg;

    localparam logic        RST_ENABLE     = 1'b0;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

    localparam logic [5:0]  STALL_NONE     = 6'b000000;
    localparam logic [5:0]  STALL_FROM_ID  = 6'b000111;
    localparam logic [5:0]  STALL_FROM_EX  = 6'b001111;
    localparam logic [5:0]  STALL_FROM_MEM = 6'b011111;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_e;

    // The furthest-downstream requester wins because its mask covers all upstream stages.
    function automatic logic [5:0] merge_stall(input logic id_req,
                                               input logic ex_req,
                                               input logic mem_req);
        if (mem_req)     return STALL_FROM_MEM;
        else if (ex_req) return STALL_FROM_EX;
        else if (id_req) return STALL_FROM_ID;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall watchdog: saturating consecutive-stall counter, sticky timeout flag
// and a free-running 32-bit count of stalled cycles.
module pipeline_ctrl_stall_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int WDOG_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_MAX);

    logic [CNT_W-1:0] run_cnt;
    logic             counting;

    assign counting = stall_i && !flush_i;

    // Timeout fires on the edge where the run length reaches CNT_MAX.
    always_ff @(posedge Clk) begin
        if (Rst_n == RST_ENABLE) begin
            run_cnt         <= '0;
            stall_timeout_o <= 1'b0;
            stall_cycles_o  <= ZERO_WORD;
        end else begin
            if (counting) begin
                if (run_cnt != CNT_MAX) begin
                    run_cnt <= run_cnt + 1'b1;
                end
                if (run_cnt >= CNT_MAX - 1'b1) begin
                    stall_timeout_o <= 1'b1;
                end
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: merges stage stall requests, sequences one-cycle
// flushes with PC redirect and feeds the stall watchdog.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WDOG_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        flush_req_i,
    input  logic [31:0] flush_pc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o
);

    ctrl_state_e state;

    // A flush cycle silences every stall request; reset also forces all stages to run.
    always_comb begin
        stall_o = STALL_NONE;
        if (Rst_n != RST_ENABLE && state != FLUSH) begin
            stall_o = merge_stall(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n == RST_ENABLE) begin
            state    <= RUN;
            flush_o  <= 1'b0;
            new_pc_o <= ZERO_WORD;
        end else begin
            case (state)
                RUN: begin
                    if (flush_req_i) begin
                        state    <= FLUSH;
                        flush_o  <= 1'b1;
                        new_pc_o <= flush_pc_i;
                    end
                end
                FLUSH: begin
                    if (flush_req_i) begin
                        state    <= FLUSH;
                        flush_o  <= 1'b1;
                        new_pc_o <= flush_pc_i;
                    end else begin
                        state    <= RUN;
                        flush_o  <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

    pipeline_ctrl_stall_watchdog #(
        .WDOG_MAX (WDOG_MAX),
        .CNT_W    (CNT_W)
    ) u_stall_watchdog (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .stall_i         (stall_o[0]),
        .flush_i         (flush_o),
        .stall_timeout_o (stall_timeout_o),
        .stall_cycles_o  (stall_cycles_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int WDOG = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        stallreq_ex_i = 1'b0;
    logic        stallreq_mem_i = 1'b0;
    logic        flush_req_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_timeout_o;
    logic [31:0] stall_cycles_o;

    int errors = 0;
    int checks = 0;

    // Model state: what the outputs must show during the current cycle.
    bit          m_flushing = 1'b0;
    logic [31:0] m_pc       = 32'h0;
    int          m_run      = 0;
    bit          m_timeout  = 1'b0;
    logic [31:0] m_cycles   = 32'h0;

    pipeline_ctrl #(.WDOG_MAX(WDOG), .CNT_W(3)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .stallreq_mem_i  (stallreq_mem_i),
        .flush_req_i     (flush_req_i),
        .flush_pc_i      (flush_pc_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .stall_timeout_o (stall_timeout_o),
        .stall_cycles_o  (stall_cycles_o)
    );

    always #5 Clk = ~Clk;

    // Stages from PC up to the furthest requester halt; nothing halts in reset or flush.
    function automatic logic [5:0] expStall();
        int depth;
        if (!Rst_n || m_flushing) return 6'd0;
        depth = stallreq_mem_i ? 5 : stallreq_ex_i ? 4 : stallreq_id_i ? 3 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    always @(posedge Clk) begin
        if (!Rst_n) begin
            m_flushing = 1'b0;
            m_pc       = 32'h0;
            m_run      = 0;
            m_timeout  = 1'b0;
            m_cycles   = 32'h0;
        end else begin
            if (expStall() != 6'd0) begin
                m_cycles = m_cycles + 32'd1;
                m_run    = (m_run + 1 > WDOG) ? WDOG : m_run + 1;
                if (m_run == WDOG) m_timeout = 1'b1;
            end else begin
                m_run = 0;
            end
            m_flushing = flush_req_i;
            if (flush_req_i) m_pc = flush_pc_i;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        cmp("stall_o",         32'(stall_o),         32'(expStall()));
        cmp("flush_o",         32'(flush_o),         32'(m_flushing));
        cmp("new_pc_o",        new_pc_o,             m_pc);
        cmp("stall_timeout_o", 32'(stall_timeout_o), 32'(m_timeout));
        cmp("stall_cycles_o",  stall_cycles_o,       m_cycles);
    endtask

    // Drives one cycle of inputs after the falling edge, then checks against the model.
    task automatic applyStimulus(input logic id, input logic ex, input logic mem,
                                 input logic fl, input logic [31:0] pc, input logic rst_n);
        @(negedge Clk);
        stallreq_id_i  = id;
        stallreq_ex_i  = ex;
        stallreq_mem_i = mem;
        flush_req_i    = fl;
        flush_pc_i     = pc;
        Rst_n          = rst_n;
        #1;
        checkOutput();
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        cmp("rst_stall", 32'(stall_o), 32'h0);
        cmp("rst_flush", 32'(flush_o), 32'h0);
        cmp("rst_pc", new_pc_o, 32'h0);
        cmp("rst_cycles", stall_cycles_o, 32'h0);

        applyStimulus(1, 0, 0, 0, 32'h0, 1);
        cmp("id_stall", 32'(stall_o), 32'h07);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        cmp("id_release", 32'(stall_o), 32'h00);
        cmp("id_cycles", stall_cycles_o, 32'd1);

        applyStimulus(1, 1, 1, 0, 32'h0, 1);
        cmp("all_stall", 32'(stall_o), 32'h1F);
        applyStimulus(1, 1, 0, 0, 32'h0, 1);
        cmp("ex_stall", 32'(stall_o), 32'h0F);
        applyStimulus(1, 0, 0, 0, 32'h0, 1);
        cmp("id_only", 32'(stall_o), 32'h07);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);

        applyStimulus(0, 1, 0, 1, 32'hBFC00380, 1);
        cmp("flushN_stall", 32'(stall_o), 32'h0F);
        applyStimulus(0, 1, 0, 0, 32'h0, 1);
        cmp("flushN1_flush", 32'(flush_o), 32'h1);
        cmp("flushN1_pc", new_pc_o, 32'hBFC00380);
        cmp("flushN1_stall", 32'(stall_o), 32'h00);
        applyStimulus(0, 1, 0, 0, 32'h0, 1);
        cmp("flushN2_stall", 32'(stall_o), 32'h0F);
        cmp("flushN2_flush", 32'(flush_o), 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);

        applyStimulus(0, 0, 0, 1, 32'h100, 1);
        applyStimulus(0, 0, 0, 1, 32'h200, 1);
        cmp("b2b_flush1", 32'(flush_o), 32'h1);
        cmp("b2b_pc1", new_pc_o, 32'h100);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        cmp("b2b_flush2", 32'(flush_o), 32'h1);
        cmp("b2b_pc2", new_pc_o, 32'h200);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        cmp("b2b_done", 32'(flush_o), 32'h0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, 0, 32'h0, 1);
            if (i == 3) cmp("wdog_before", 32'(stall_timeout_o), 32'h0);
            if (i == 4) cmp("wdog_after", 32'(stall_timeout_o), 32'h1);
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        cmp("wdog_sticky", 32'(stall_timeout_o), 32'h1);

        applyStimulus(0, 0, 1, 1, 32'h300, 1);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        cmp("rstflush_flush", 32'(flush_o), 32'h1);
        cmp("rstflush_stall", 32'(stall_o), 32'h00);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        cmp("postrst_flush", 32'(flush_o), 32'h0);
        cmp("postrst_pc", new_pc_o, 32'h0);
        cmp("postrst_timeout", 32'(stall_timeout_o), 32'h0);
        cmp("postrst_cycles", stall_cycles_o, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
                          $urandom(), ($urandom_range(0, 149) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
